// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: CPU request/response handshake plus the data_memory port of the LSU.
// master is the LSU view, slave is the CPU/memory side.
interface lsu_mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_read_data;
   modport master (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_write_data, mem_write_enable, mem_funct3
   );
   modport slave (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_write_data, mem_write_enable, mem_funct3
   );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-at-a-time load/store initiator driving data_memory through registered outputs.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned halfword/word accesses into byte beats.
module lsu_mem_master (
   input logic              clk,
   input logic              rst,
   lsu_mem_master_if.master lsu
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   state_e      state_q;
   logic        req_ready_q, resp_valid_q, resp_error_q, mem_we_q, write_q;
   logic [31:0] resp_rdata_q, mem_addr_q, mem_wdata_q;
   logic [2:0]  mem_f3_q;
   logic        accept, legal, last;
   logic [2:0]  beat0_f3;
   logic [31:0] beat0_wdata, nxt_addr, nxt_wdata, rdata_d;
   assign accept = lsu.req_valid && req_ready_q;
   assign legal = lsu.req_write ? lsu.req_funct3 inside {3'b000, 3'b001, 3'b010}
                                : lsu.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef LSU_MISALIGN_SPLIT_EN
   logic        split, split_q;
   logic [1:0]  beat_q, last_beat_q, beat_nxt;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, acc_q, merged;
   assign split = (lsu.req_funct3[1:0] == 2'b01 && lsu.req_addr[0]) ||
                  (lsu.req_funct3[1:0] == 2'b10 && lsu.req_addr[1:0] != 2'b00);
   assign beat_nxt = beat_q + 2'd1;
   assign beat0_f3 = split ? (lsu.req_write ? 3'b000 : 3'b100) : lsu.req_funct3;
   assign beat0_wdata = split ? {24'h0, lsu.req_wdata[7:0]} : lsu.req_wdata;
   assign nxt_addr = addr_q + {30'h0, beat_nxt};
   assign nxt_wdata = {24'h0, wdata_q[{beat_nxt, 3'b000} +: 8]};
   assign last = !split_q || beat_q == last_beat_q;
   // current beat's byte merged with the bytes captured so far
   always_comb begin
      merged = acc_q;
      merged[{beat_q, 3'b000} +: 8] = lsu.mem_read_data[7:0];
   end
   assign rdata_d = write_q ? 32'h0 :
                    !split_q ? lsu.mem_read_data :
                    f3_q == 3'b001 ? {{16{merged[15]}}, merged[15:0]} :
                    f3_q == 3'b101 ? {16'h0, merged[15:0]} : merged;
   always_ff @(posedge clk) begin
      if (rst) begin
         split_q     <= 1'b0;
         beat_q      <= 2'd0;
         last_beat_q <= 2'd0;
         f3_q        <= 3'd0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         acc_q       <= 32'h0;
      end else if (accept) begin
         split_q     <= split;
         beat_q      <= 2'd0;
         last_beat_q <= lsu.req_funct3[1:0] == 2'b10 ? 2'd3 : 2'd1;
         f3_q        <= lsu.req_funct3;
         addr_q      <= lsu.req_addr;
         wdata_q     <= lsu.req_wdata;
         acc_q       <= 32'h0;
      end else if (state_q == ACCESS) begin
         beat_q <= beat_nxt;
         acc_q  <= merged;
      end
   end
`else
   assign beat0_f3 = lsu.req_funct3;
   assign beat0_wdata = lsu.req_wdata;
   assign nxt_addr = mem_addr_q;
   assign nxt_wdata = mem_wdata_q;
   assign last = 1'b1;
   assign rdata_d = write_q ? 32'h0 : lsu.mem_read_data;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         write_q      <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_f3_q     <= 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= !accept;
               if (accept) begin
                  write_q <= lsu.req_write;
                  if (legal) begin
                     state_q     <= ACCESS;
                     mem_we_q    <= lsu.req_write;
                     mem_addr_q  <= lsu.req_addr;
                     mem_wdata_q <= beat0_wdata;
                     mem_f3_q    <= beat0_f3;
                  end else begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_error_q <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (last) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= rdata_d;
                  mem_we_q     <= 1'b0;
                  mem_addr_q   <= 32'h0;
                  mem_wdata_q  <= 32'h0;
                  mem_f3_q     <= 3'd0;
               end else begin
                  mem_addr_q  <= nxt_addr;
                  mem_wdata_q <= nxt_wdata;
               end
            end
            RESP: begin
               if (lsu.resp_ready) begin
                  state_q      <= IDLE;
                  req_ready_q  <= 1'b1;
                  resp_valid_q <= 1'b0;
                  resp_error_q <= 1'b0;
                  resp_rdata_q <= 32'h0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign lsu.req_ready        = req_ready_q;
   assign lsu.resp_valid       = resp_valid_q;
   assign lsu.resp_error       = resp_error_q;
   assign lsu.resp_rdata       = resp_rdata_q;
   assign lsu.mem_write_enable = mem_we_q;
   assign lsu.mem_address      = mem_addr_q;
   assign lsu.mem_write_data   = mem_wdata_q;
   assign lsu.mem_funct3       = mem_f3_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed bench for lsu_mem_master with a byte-addressed data_memory model.
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined for the build.
module tb_lsu_mem_master;
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   bit [7:0] mem [0:1023];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [2:0]  wr_f3[$];
   logic [9:0]  a0;
   logic [7:0]  rb0, rb1, rb2, rb3;
   lsu_mem_master_if bus();
   lsu_mem_master dut (.clk(clk), .rst(rst), .lsu(bus));
   always #5 clk = ~clk;
   assign a0  = bus.mem_address[9:0];
   assign rb0 = mem[a0];
   assign rb1 = mem[a0 + 10'd1];
   assign rb2 = mem[a0 + 10'd2];
   assign rb3 = mem[a0 + 10'd3];
   assign bus.mem_read_data = bus.mem_funct3 == 3'b000 ? {{24{rb0[7]}}, rb0} :
                              bus.mem_funct3 == 3'b100 ? {24'h0, rb0} :
                              bus.mem_funct3 == 3'b001 ? {{16{rb1[7]}}, rb1, rb0} :
                              bus.mem_funct3 == 3'b101 ? {16'h0, rb1, rb0} : {rb3, rb2, rb1, rb0};
   // memory model: writes at the edge ending each write cycle and logs every write beat
   always @(posedge clk) begin
      if (bus.mem_write_enable) begin
         wr_addr.push_back(bus.mem_address);
         wr_data.push_back(bus.mem_write_data);
         wr_f3.push_back(bus.mem_funct3);
         for (int i = 0; i < 4; i++)
            if (i < (bus.mem_funct3[1:0] == 2'b00 ? 1 : bus.mem_funct3[1:0] == 2'b01 ? 2 : 4))
               mem[10'(bus.mem_address + 32'(i))] <= bus.mem_write_data[8*i +: 8];
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic clr_log();
      wr_addr.delete();
      wr_data.delete();
      wr_f3.delete();
   endtask
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int k = 0;
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      while (!bus.req_ready && k < 20) begin
         step();
         k++;
      end
      if (k >= 20) begin
         errors++;
         $error("FAIL accept_timeout: req_ready never rose for addr 0x%08h", a);
      end
      step();
      bus.req_valid = 1'b0;
   endtask
   task automatic wait_resp(output int lat);
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask
   task automatic xfer(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er);
      issue(wr, f3, a, d);
      wait_resp(lat);
      rd = bus.resp_rdata;
      er = bus.resp_error;
      step();
   endtask
   initial begin
      int lat;
      int n;
      logic [31:0] rd;
      logic [31:0] w;
      logic er;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'd100;
      bus.req_wdata  = 32'hFFFF_FFFF;
      bus.resp_ready = 1'b1;
      repeat (3) step();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_error", bus.resp_error, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_mem_we", bus.mem_write_enable, 0);
      chk("rst_mem_addr", bus.mem_address, 0);
      chk("rst_mem_wdata", bus.mem_write_data, 0);
      chk("rst_mem_f3", bus.mem_funct3, 0);
      bus.req_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("req_ready_after_rst", bus.req_ready, 1);
      chk("rst_req_dropped", wr_addr.size(), 0);
      clr_log();
      xfer(1'b1, 3'b010, 32'd100, 32'hDEADBEEF, lat, rd, er);
      chk("sw_latency", lat, 2);
      chk("sw_rdata", rd, 0);
      chk("sw_error", er, 0);
      chk("sw_beats", wr_addr.size(), 1);
      chk("sw_addr", wr_addr[0], 32'd100);
      chk("sw_f3", wr_f3[0], 3'b010);
      chk("sw_wdata", wr_data[0], 32'hDEADBEEF);
      xfer(1'b0, 3'b010, 32'd100, 32'h0, lat, rd, er);
      chk("lw_latency", lat, 2);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      xfer(1'b0, 3'b000, 32'd103, 32'h0, lat, rd, er);
      chk("lb_rdata", rd, 32'hFFFFFFDE);
      xfer(1'b0, 3'b100, 32'd103, 32'h0, lat, rd, er);
      chk("lbu_rdata", rd, 32'h000000DE);
      xfer(1'b1, 3'b001, 32'd200, 32'h1234ABCD, lat, rd, er);
      chk("sh_latency", lat, 2);
      xfer(1'b0, 3'b001, 32'd200, 32'h0, lat, rd, er);
      chk("lh_rdata", rd, 32'hFFFFABCD);
      xfer(1'b0, 3'b101, 32'd200, 32'h0, lat, rd, er);
      chk("lhu_rdata", rd, 32'h0000ABCD);
      clr_log();
      xfer(1'b1, 3'b011, 32'd300, 32'h55555555, lat, rd, er);
      chk("err_store_latency", lat, 1);
      chk("err_store_flag", er, 1);
      chk("err_store_rdata", rd, 0);
      chk("err_store_no_write", wr_addr.size(), 0);
      xfer(1'b0, 3'b110, 32'd300, 32'h0, lat, rd, er);
      chk("err_load_latency", lat, 1);
      chk("err_load_flag", er, 1);
      bus.resp_ready = 1'b0;
      issue(1'b0, 3'b010, 32'd100, 32'h0);
      wait_resp(lat);
      chk("bp_latency", lat, 2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid_held", bus.resp_valid, 1);
         chk("bp_rdata_held", bus.resp_rdata, 32'hDEADBEEF);
         chk("bp_req_ready_low", bus.req_ready, 0);
      end
      bus.resp_ready = 1'b1;
      step();
      chk("bp_resp_done", bus.resp_valid, 0);
      chk("bp_back_idle", bus.req_ready, 1);
      clr_log();
      w = 32'h11223344;
      xfer(1'b1, 3'b010, 32'd401, w, lat, rd, er);
      n = SPLIT ? 4 : 1;
      chk("mis_sw_latency", lat, SPLIT ? 5 : 2);
      chk("mis_sw_beats", wr_addr.size(), n);
      for (int i = 0; i < n; i++) begin
         chk("mis_sw_addr", wr_addr[i], 32'd401 + 32'(i));
         chk("mis_sw_f3", wr_f3[i], SPLIT ? 3'b000 : 3'b010);
         chk("mis_sw_wdata", wr_data[i], SPLIT ? {24'h0, w[8*i +: 8]} : w);
      end
      xfer(1'b0, 3'b010, 32'd401, 32'h0, lat, rd, er);
      chk("mis_lw_latency", lat, SPLIT ? 5 : 2);
      chk("mis_lw_rdata", rd, 32'h11223344);
      xfer(1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000034, lat, rd, er);
      xfer(1'b1, 3'b000, 32'h00000000, 32'h00000092, lat, rd, er);
      xfer(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, lat, rd, er);
      chk("wrap_lh_latency", lat, SPLIT ? 3 : 2);
      chk("wrap_lh_rdata", rd, 32'hFFFF9234);
      xfer(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, lat, rd, er);
      chk("wrap_lhu_rdata", rd, 32'h00009234);
      clr_log();
      issue(1'b1, 3'b010, 32'd501, 32'hAABBCCDD);
      if (SPLIT) step();
      rst = 1'b1;
      step();
      chk("mid_rst_req_ready", bus.req_ready, 0);
      chk("mid_rst_resp_valid", bus.resp_valid, 0);
      chk("mid_rst_mem_we", bus.mem_write_enable, 0);
      chk("mid_rst_mem_addr", bus.mem_address, 0);
      chk("mid_rst_mem_wdata", bus.mem_write_data, 0);
      chk("mid_rst_mem_f3", bus.mem_funct3, 0);
      rst = 1'b0;
      n = 0;
      repeat (5) begin
         step();
         n += int'(bus.resp_valid);
      end
      chk("mid_rst_no_resp", n, 0);
      chk("mid_rst_beats", wr_addr.size(), SPLIT ? 2 : 1);
      chk("mid_rst_byte0", mem[501], 8'hDD);
      chk("mid_rst_byte1", mem[502], 8'hCC);
      chk("mid_rst_byte2", mem[503], SPLIT ? 8'h00 : 8'hBB);
      chk("mid_rst_idle", bus.req_ready, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
